id_stage: RTL

- Instruction-decode stage and ID/EX pipeline register that drives the EX stage inputs: rs, rt, sign_ext, pc, ALUSrc, ALUOp, funct, branch.
- Decodes a 32-bit MIPS instruction, reads a 32x32 register file, and generates control.
- Detects load-use hazards and registers all results for EX one cycle later.
- Sits between the IF/ID register and the EX stage; writeback from MEM/WB enters through the wb_* ports.

---
 rtl/id_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// MIPS decode stage with 32x32 register file and ID/EX pipeline register.
// Load-use hazard detection is compiled in only when HAZARD_DETECT_EN is defined.
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] sign_ext,
  output logic [DATA_W-1:0] pc,
  output logic              ALUSrc,
  output logic [1:0]        ALUOp,
  output logic [5:0]        funct,
  output logic              branch,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic [4:0]        rd_addr,
  output logic              valid_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [5:0] opcode;
  logic [4:0] rs_idx, rt_idx;
  assign opcode = instr_in[31:26];
  assign rs_idx = instr_in[25:21];
  assign rt_idx = instr_in[20:16];

  // Register file
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [DATA_W-1:0] rf_d [REG_COUNT];

  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads bypass a same-cycle writeback so EX never sees a stale operand.
  logic [DATA_W-1:0] rs_val, rt_val;
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != 5'd0) rs_val = (wb_en && wb_addr == rs_idx) ? wb_data : rf_q[rs_idx];
    if (rt_idx != 5'd0) rt_val = (wb_en && wb_addr == rt_idx) ? wb_data : rf_q[rt_idx];
  end

  // Decode
  logic       dec_known, dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic       dec_alu_src, dec_branch;
  logic [1:0] dec_alu_op;
  logic [4:0] dec_rd_addr;

  always_comb begin
    dec_known      = 1'b1;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_op     = 2'b00;
    dec_rd_addr    = (opcode == OP_RTYPE) ? instr_in[15:11] : rt_idx;
    case (opcode)
      OP_RTYPE: begin dec_alu_op = 2'b10; dec_reg_write = 1'b1; end
      OP_LW: begin
        dec_alu_src = 1'b1; dec_mem_read = 1'b1; dec_mem_to_reg = 1'b1; dec_reg_write = 1'b1;
      end
      OP_SW:   begin dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      OP_BEQ:  begin dec_alu_op = 2'b01; dec_branch = 1'b1; end
      OP_ADDI: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      default: dec_known = 1'b0;
    endcase
  end

  // ID/EX register
  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic              alu_src_q, alu_src_d, branch_q, branch_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d, sign_ext_q, sign_ext_d, pc_q, pc_d;
  logic [5:0]        funct_q, funct_d;
  logic [4:0]        rd_addr_q, rd_addr_d;

  logic hazard;
`ifdef HAZARD_DETECT_EN
  logic uses_rt;
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign hazard  = valid_q && mem_read_q && (rd_addr_q != 5'd0) &&
                   ((rd_addr_q == rs_idx) || (uses_rt && rd_addr_q == rt_idx));
`else
  assign hazard = 1'b0;
`endif

  assign stall_out = stall || (hazard && !flush);

  logic load_ctrl;
  assign load_ctrl = valid_in && dec_known && !flush && !hazard;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    branch_d     = branch_q;
    alu_op_d     = alu_op_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    sign_ext_d   = sign_ext_q;
    pc_d         = pc_q;
    funct_d      = funct_q;
    rd_addr_d    = rd_addr_q;
    if (!stall) begin
      // Data fields follow instr_in even into a bubble; only control is squashed.
      rs_d         = rs_val;
      rt_d         = rt_val;
      sign_ext_d   = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
      pc_d         = pc_in;
      funct_d      = instr_in[5:0];
      rd_addr_d    = dec_rd_addr;
      valid_d      = load_ctrl;
      reg_write_d  = load_ctrl && dec_reg_write;
      mem_read_d   = load_ctrl && dec_mem_read;
      mem_write_d  = load_ctrl && dec_mem_write;
      mem_to_reg_d = load_ctrl && dec_mem_to_reg;
      alu_src_d    = load_ctrl && dec_alu_src;
      branch_d     = load_ctrl && dec_branch;
      alu_op_d     = load_ctrl ? dec_alu_op : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      alu_op_q     <= 2'b00;
      rs_q         <= '0;
      rt_q         <= '0;
      sign_ext_q   <= '0;
      pc_q         <= '0;
      funct_q      <= '0;
      rd_addr_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      alu_op_q     <= alu_op_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      sign_ext_q   <= sign_ext_d;
      pc_q         <= pc_d;
      funct_q      <= funct_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign valid_out = valid_q;
  assign RegWrite  = reg_write_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign MemtoReg  = mem_to_reg_q;
  assign ALUSrc    = alu_src_q;
  assign branch    = branch_q;
  assign ALUOp     = alu_op_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign sign_ext  = sign_ext_q;
  assign pc        = pc_q;
  assign funct     = funct_q;
  assign rd_addr   = rd_addr_q;

endmodule
